// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the ARMv8-subset datapath: FETCH/DECODE/EXEC/MEM/WB
// with ready handshakes, per-wait timeout watchdog, illegal-opcode trap and retire counter.
module multicycle_sequencer #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg2loc,
    output logic             alusrc,
    output logic             mem2reg,
    output logic             regwrite,
    output logic [3:0]       aluop,
    output logic [2:0]       signop,
    output logic [2:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_AND, C_ORR, C_ADD, C_MOVZ, C_SUB, C_ADDI,
        C_SUBI, C_B, C_CBZ, C_LDUR, C_STUR
    } class_t;

    typedef struct packed {
        class_t     cls;
        logic       reg2loc;
        logic       alusrc;
        logic       mem2reg;
        logic [3:0] aluop;
        logic [2:0] signop;
    } ctrl_t;

    // Priority order matters: the first matching pattern defines the class.
    function automatic ctrl_t decode_op(input logic [10:0] op);
        ctrl_t c;
        c = '0;
        casez (op)
            11'b?0001010???: begin c.cls = C_AND;  c.aluop = 4'b0000; end
            11'b?0101010???: begin c.cls = C_ORR;  c.aluop = 4'b0001; end
            11'b?0?01011???: begin c.cls = C_ADD;  c.aluop = 4'b0010; end
            11'b110100101??: begin
                c.cls    = C_MOVZ;
                c.alusrc = 1'b1;
                c.aluop  = 4'b0111;
                c.signop = {1'b1, op[1:0]};
            end
            11'b?1?01011???: begin c.cls = C_SUB;  c.aluop = 4'b0110; end
            11'b?0?10001???: begin c.cls = C_ADDI; c.alusrc = 1'b1; c.aluop = 4'b0010; end
            11'b?1?10001???: begin c.cls = C_SUBI; c.alusrc = 1'b1; c.aluop = 4'b0110; end
            11'b?00101?????: begin c.cls = C_B;    c.signop = 3'b010; end
            11'b?011010????: begin
                c.cls     = C_CBZ;
                c.reg2loc = 1'b1;
                c.aluop   = 4'b0111;
                c.signop  = 3'b011;
            end
            11'b??111000010: begin
                c.cls     = C_LDUR;
                c.alusrc  = 1'b1;
                c.mem2reg = 1'b1;
                c.aluop   = 4'b0010;
                c.signop  = 3'b001;
            end
            11'b??111000000: begin
                c.cls     = C_STUR;
                c.reg2loc = 1'b1;
                c.alusrc  = 1'b1;
                c.aluop   = 4'b0010;
                c.signop  = 3'b001;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t           state_q, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] retired_q;
    logic             trap_q;
    logic [1:0]       cause_q, cause_c;
    logic             count_en, last_wait, in_instr;
    logic             imem_req_c, ir_write_c, dmem_rd_c, dmem_wr_c;
    logic             pc_write_c, pc_src_c, regwrite_c;
    ctrl_t            dec, held, cur, vis;

    assign dec       = decode_op(opcode);
    assign cur       = (state_q == S_DECODE) ? dec : held;
    assign last_wait = (wait_cnt == WAIT_W'(MAX_WAIT - 1));
    assign in_instr  = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                       (state_q == S_MEM)    || (state_q == S_WB);
    assign vis       = (in_instr && !reset) ? cur : '0;

    // Opcode is only guaranteed during DECODE, so the decoded fields are held for later states.
    always_ff @(posedge CLK) begin
        if (state_q == S_DECODE) held <= dec;
    end

    always_comb begin
        next_state = state_q;
        imem_req_c = 1'b0;
        ir_write_c = 1'b0;
        dmem_rd_c  = 1'b0;
        dmem_wr_c  = 1'b0;
        pc_write_c = 1'b0;
        pc_src_c   = 1'b0;
        regwrite_c = 1'b0;
        count_en   = 1'b0;
        cause_c    = 2'b00;
        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_write_c = 1'b1;
                    next_state = S_DECODE;
                end else if (last_wait) begin
                    next_state = S_TRAP;
                    cause_c    = 2'b10;
                end else begin
                    count_en = 1'b1;
                end
            end
            S_DECODE: begin
                if (dec.cls == C_NONE) begin
                    next_state = S_TRAP;
                    cause_c    = 2'b01;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cur.cls)
                    C_LDUR, C_STUR: next_state = S_MEM;
                    C_B: begin
                        pc_write_c = 1'b1;
                        pc_src_c   = 1'b1;
                        next_state = S_FETCH;
                    end
                    C_CBZ: begin
                        pc_write_c = 1'b1;
                        pc_src_c   = zero;
                        next_state = S_FETCH;
                    end
                    default: next_state = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_rd_c = (cur.cls == C_LDUR);
                dmem_wr_c = (cur.cls != C_LDUR);
                if (dmem_ready) begin
                    if (cur.cls == C_LDUR) begin
                        next_state = S_WB;
                    end else begin
                        pc_write_c = 1'b1;
                        next_state = S_FETCH;
                    end
                end else if (last_wait) begin
                    next_state = S_TRAP;
                    cause_c    = 2'b11;
                end else begin
                    count_en = 1'b1;
                end
            end
            S_WB: begin
                regwrite_c = 1'b1;
                pc_write_c = 1'b1;
                next_state = S_FETCH;
            end
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_cnt  <= '0;
            retired_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            state_q <= next_state;
            if (next_state != state_q)
                wait_cnt <= '0;
            else if (count_en)
                wait_cnt <= wait_cnt + 1'b1;
            if (pc_write_c)
                retired_q <= retired_q + 1'b1;
            if (next_state == S_TRAP && state_q != S_TRAP) begin
                trap_q  <= 1'b1;
                cause_q <= cause_c;
            end
        end
    end

    // Reset gates every combinational output so an abandoned instruction cannot write.
    assign imem_req   = imem_req_c & ~reset;
    assign ir_write   = ir_write_c & ~reset;
    assign dmem_rd    = dmem_rd_c  & ~reset;
    assign dmem_wr    = dmem_wr_c  & ~reset;
    assign pc_write   = pc_write_c & ~reset;
    assign pc_src     = pc_src_c   & ~reset;
    assign regwrite   = regwrite_c & ~reset;
    assign reg2loc    = vis.reg2loc;
    assign alusrc     = vis.alusrc;
    assign mem2reg    = vis.mem2reg;
    assign aluop      = vis.aluop;
    assign signop     = vis.signop;
    assign state      = state_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized scoreboard bench for multicycle_sequencer: a stimulus process queues
// expected per-instruction outcomes, a monitor pops and compares them.
module tb_multicycle_sequencer;

    localparam int MAX_WAIT = 16;
    localparam int CNT_W    = 32;

    logic             CLK, reset;
    logic [10:0]      opcode;
    logic             zero, imem_ready, dmem_ready;
    logic             imem_req, ir_write, dmem_rd, dmem_wr, pc_write, pc_src;
    logic             reg2loc, alusrc, mem2reg, regwrite;
    logic [3:0]       aluop;
    logic [2:0]       signop, state;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] retired;

    multicycle_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .reset(reset), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .pc_write(pc_write), .pc_src(pc_src), .reg2loc(reg2loc), .alusrc(alusrc),
        .mem2reg(mem2reg), .regwrite(regwrite), .aluop(aluop), .signop(signop),
        .state(state), .trap(trap), .trap_cause(trap_cause), .retired(retired)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int tests = 0;
    int fails = 0;
    int exp_ret = 0;

    typedef struct {
        bit is_trap;
        int cause;
        int cycles;
        bit pc_src;
        int regw;
        int aluop;
        int signop;
        bit alusrc;
        bit reg2loc;
        bit mem2reg;
        int rd_cyc;
        int wr_cyc;
        int ret_before;
    } exp_t;

    exp_t sb[$];

    // Instruction classes in priority order: AND ORR ADD MOVZ SUB ADDI SUBI B CBZ LDUR STUR
    localparam int K_MOVZ = 3, K_B = 7, K_CBZ = 8, K_LDUR = 9, K_STUR = 10;
    logic [10:0] pmask [11] = '{11'b01111111000, 11'b01111111000, 11'b01011111000,
                                11'b11111111100, 11'b01011111000, 11'b01011111000,
                                11'b01011111000, 11'b01111100000, 11'b01111110000,
                                11'b00111111111, 11'b00111111111};
    logic [10:0] pval  [11] = '{11'b00001010000, 11'b00101010000, 11'b00001011000,
                                11'b11010010100, 11'b01001011000, 11'b00010001000,
                                11'b01010001000, 11'b00010100000, 11'b00110100000,
                                11'b00111000010, 11'b00111000000};
    int tbl_aluop  [11] = '{0, 1, 2, 7, 6, 2, 6, 0, 7, 2, 2};
    int tbl_signop [11] = '{0, 0, 0, 4, 0, 0, 0, 2, 3, 1, 1};
    bit tbl_alusrc [11] = '{0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1};
    bit tbl_reg2loc[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int classify(input logic [10:0] op);
        for (int i = 0; i < 11; i++)
            if ((op & pmask[i]) == pval[i]) return i;
        return -1;
    endfunction

    function automatic exp_t model(input logic [10:0] op, input bit z,
                                   input int idly, input int ddly, input int ret);
        exp_t e;
        int   c, fetch, memc;
        e = '{default: 0};
        e.ret_before = ret;
        c = classify(op);
        fetch = idly + 1;
        if (idly >= MAX_WAIT) begin
            e.is_trap = 1; e.cause = 2; e.cycles = MAX_WAIT;
            return e;
        end
        if (c < 0) begin
            e.is_trap = 1; e.cause = 1; e.cycles = fetch + 1;
            return e;
        end
        e.aluop   = tbl_aluop[c];
        e.signop  = tbl_signop[c] + ((c == K_MOVZ) ? int'(op[1:0]) : 0);
        e.alusrc  = tbl_alusrc[c];
        e.reg2loc = tbl_reg2loc[c];
        e.mem2reg = (c == K_LDUR);
        if (c == K_B || c == K_CBZ) begin
            e.cycles = fetch + 2;
            e.pc_src = (c == K_B) ? 1'b1 : z;
        end else if (c == K_LDUR || c == K_STUR) begin
            if (ddly >= MAX_WAIT) begin
                e.is_trap = 1; e.cause = 3; e.cycles = fetch + 2 + MAX_WAIT;
                return e;
            end
            memc = ddly + 1;
            if (c == K_LDUR) begin
                e.cycles = fetch + 2 + memc + 1; e.rd_cyc = memc; e.regw = 1;
            end else begin
                e.cycles = fetch + 2 + memc; e.wr_cyc = memc;
            end
        end else begin
            e.cycles = fetch + 3;
            e.regw   = 1;
        end
        return e;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
        #2;
        chk("rst_state", state, 0);
        chk("rst_outs", {imem_req, ir_write, dmem_rd, dmem_wr, pc_write, pc_src, reg2loc,
                         alusrc, mem2reg, regwrite, aluop, signop, trap, trap_cause}, 0);
        chk("rst_retired", retired, 0);
        @(negedge CLK);
        reset = 1'b0;
        exp_ret = 0;
    endtask

    // Called at a negedge while the DUT sits in its first FETCH cycle.
    task automatic issue(input logic [10:0] op, input bit z, input int idly, input int ddly);
        exp_t e;
        int fk, mk, guard;
        logic [2:0] st;
        e = model(op, z, idly, ddly, exp_ret);
        sb.push_back(e);
        if (!e.is_trap) exp_ret++;
        opcode = op; zero = z;
        fk = 0; mk = 0; guard = 0;
        forever begin
            st = state;
            imem_ready = (st == 3'd0) && (fk == idly);
            dmem_ready = (st == 3'd3) && (mk == ddly);
            if (st == 3'd0) fk++;
            if (st == 3'd3) mk++;
            @(negedge CLK);
            guard++;
            if (state == 3'd7) break;
            if (state == 3'd0 && st != 3'd0) break;
            if (guard > 200) begin
                chk("instr_timeout", guard, 0);
                break;
            end
        end
        imem_ready = 1'b0; dmem_ready = 1'b0;
        if (state != 3'd0) do_reset();
    endtask

    // Monitor: accumulates per-instruction observations and scores at retire or trap entry.
    initial begin
        int cyc, regw, rdc, wrc, irw, pcw;
        logic [2:0] prev;
        bit tseen;
        exp_t e;
        logic [3:0] a_q;
        logic [2:0] s_q;
        logic src_q, r2l_q, m2r_q;
        cyc = 0; regw = 0; rdc = 0; wrc = 0; irw = 0; pcw = 0;
        prev = 3'd7; tseen = 0;
        a_q = '0; s_q = '0; src_q = 0; r2l_q = 0; m2r_q = 0;
        forever begin
            @(negedge CLK);
            #2;
            if (reset) begin
                prev = 3'd7; tseen = 0;
                continue;
            end
            if (state == 3'd7) begin
                if (!tseen) begin
                    tseen = 1;
                    if (sb.size() == 0) chk("unexpected_trap", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("trap_kind", 1, e.is_trap);
                        chk("trap_cause", trap_cause, e.cause);
                        chk("trap_cycles", cyc, e.cycles);
                        chk("trap_flag", trap, 1);
                        chk("trap_no_pcw", pcw, 0);
                        chk("trap_retired", retired, e.ret_before);
                    end
                end
                chk("trap_quiet", {imem_req, ir_write, dmem_rd, dmem_wr, pc_write, regwrite}, 0);
                prev = 3'd7;
                continue;
            end
            tseen = 0;
            if (state == 3'd0 && prev != 3'd0) begin
                cyc = 0; regw = 0; rdc = 0; wrc = 0; irw = 0; pcw = 0;
            end
            cyc++;
            if (regwrite) regw++;
            if (dmem_rd)  rdc++;
            if (dmem_wr)  wrc++;
            if (ir_write) irw++;
            if (pc_write) pcw++;
            if (state == 3'd2) begin
                a_q = aluop; s_q = signop; src_q = alusrc; r2l_q = reg2loc; m2r_q = mem2reg;
            end
            if (pc_write) begin
                if (sb.size() == 0) chk("unexpected_retire", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("ret_kind", 0, e.is_trap);
                    chk("ret_cycles", cyc, e.cycles);
                    chk("ret_pc_src", pc_src, e.pc_src);
                    chk("ret_regwrite", regw, e.regw);
                    chk("ret_ir_write", irw, 1);
                    chk("ret_aluop", a_q, e.aluop);
                    chk("ret_signop", s_q, e.signop);
                    chk("ret_alusrc", src_q, e.alusrc);
                    chk("ret_reg2loc", r2l_q, e.reg2loc);
                    chk("ret_mem2reg", m2r_q, e.mem2reg);
                    chk("ret_dmem_rd", rdc, e.rd_cyc);
                    chk("ret_dmem_wr", wrc, e.wr_cyc);
                    chk("ret_count", retired, e.ret_before);
                end
            end
            prev = state;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] op;
        int cls, r, idly, ddly;
        bit z;
        reset = 1'b1; opcode = '0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(negedge CLK);
        #2;
        chk("por_state", state, 0);
        chk("por_outs", {imem_req, ir_write, dmem_rd, dmem_wr, pc_write, regwrite, trap, trap_cause}, 0);
        chk("por_retired", retired, 0);
        @(negedge CLK);
        reset = 1'b0;
        exp_ret = 0;

        issue(11'b10001011000, 0, 0, 0);     // ADD
        issue(11'b11111000010, 0, 0, 3);     // LDUR, delayed dmem
        issue(11'b10110100101, 0, 0, 0);     // CBZ not taken
        issue(11'b10110100101, 1, 0, 0);     // CBZ taken
        issue(11'b00010100011, 0, 1, 0);     // B
        issue(11'b11010010110, 0, 0, 0);     // MOVZ hh=10
        issue(11'b00000000000, 0, 0, 0);     // illegal
        issue(11'b10001011000, 0, 100, 0);   // imem timeout
        issue(11'b10001011000, 0, 15, 0);    // ready on the last allowed cycle
        issue(11'b11111000000, 0, 0, 100);   // dmem timeout
        issue(11'b11111000000, 0, 2, 15);    // STUR, ready on the last allowed cycle
        issue(11'b11111000000, 0, 0, 0);     // STUR, immediate ready

        // Reset asserted while a STUR is waiting in MEM.
        opcode = 11'b11111000000; zero = 1'b0; imem_ready = 1'b1;
        for (int i = 0; i < 10 && state != 3'd3; i++) begin
            @(negedge CLK);
            imem_ready = 1'b0;
        end
        #2;
        chk("stur_in_mem", state, 3);
        chk("stur_dmem_wr", dmem_wr, 1);
        #1 reset = 1'b1;
        #1;
        chk("midrst_dmem_wr", dmem_wr, 0);
        chk("midrst_state", state, 0);
        chk("midrst_pc_write", {pc_write, regwrite}, 0);
        chk("midrst_retired", retired, 0);
        @(negedge CLK);
        reset = 1'b0;
        exp_ret = 0;

        for (int n = 0; n < 80; n++) begin
            cls = $urandom_range(0, 12);
            op  = 11'($urandom);
            if (cls < 11) op = (pval[cls] & pmask[cls]) | (op & ~pmask[cls]);
            r = $urandom_range(0, 19);
            idly = (r < 14) ? (r % 4) : (r < 19) ? $urandom_range(12, 15) : 100;
            r = $urandom_range(0, 19);
            ddly = (r < 14) ? (r % 4) : (r < 19) ? $urandom_range(12, 15) : 100;
            z = 1'($urandom);
            issue(op, z, idly, ddly);
        end

        repeat (3) @(negedge CLK);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
